// File: rtl/up_sampler.sv
// 2x nearest-neighbour upsampler: pops FIFO pixels, emits each twice, replays each line from a line buffer.
// Latency: rd_en at t, FIFO valid at t+1, first valid_out at t+2; the replay pass is 3 cycles per input pixel.
// Backpressure: while valid_out=1 and ready_in=0 the state and outputs hold; no pop is issued outside FETCH.
module up_sampler #(
    parameter int IN_WIDTH  = 320,
    parameter int IN_HEIGHT = 240
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       empty,
    output logic       rd_en,
    input  logic [7:0] din,
    input  logic       valid,
    input  logic       ready_in,
    output logic       valid_out,
    output logic [7:0] dout,
    output logic       sof,
    output logic       eol
);

    localparam int CW = (IN_WIDTH  > 1) ? $clog2(IN_WIDTH)  : 1;
    localparam int RW = (IN_HEIGHT > 1) ? $clog2(IN_HEIGHT) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IN_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IN_HEIGHT - 1);

    typedef enum logic [2:0] {
        FETCH,
        WAIT,
        EMIT_A,
        EMIT_B,
        REP_RD,
        REP_A,
        REP_B
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          pass_q, pass_d;
    logic [7:0]    pix_q, pix_d;
    logic          lb_we, lb_re;
    logic [7:0]    lb_q;
    logic          col_last;

    // Line buffer holds the live line for the replay pass; deliberately not reset.
    logic [7:0] line_buf [IN_WIDTH];

    always_ff @(posedge clk) begin
        if (lb_we) begin
            line_buf[col_q] <= din;
        end
        if (lb_re) begin
            lb_q <= line_buf[col_q];
        end
    end

    assign col_last = (col_q == COL_LAST);

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        pass_d    = pass_q;
        pix_d     = pix_q;
        rd_en     = 1'b0;
        valid_out = 1'b0;
        dout      = pix_q;
        sof       = 1'b0;
        eol       = 1'b0;
        lb_we     = 1'b0;
        lb_re     = 1'b0;

        case (state_q)
            FETCH: begin
                // Gated by reset so no pop escapes while the block is held in reset.
                rd_en = !empty && rst;
                if (!empty) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (valid) begin
                    pix_d   = din;
                    lb_we   = 1'b1;
                    state_d = EMIT_A;
                end
            end
            EMIT_A: begin
                valid_out = 1'b1;
                sof       = (row_q == '0) && (col_q == '0) && !pass_q;
                if (ready_in) begin
                    state_d = EMIT_B;
                end
            end
            EMIT_B: begin
                valid_out = 1'b1;
                eol       = col_last;
                if (ready_in) begin
                    if (!col_last) begin
                        col_d   = col_q + CW'(1);
                        state_d = FETCH;
                    end else begin
                        col_d   = '0;
                        pass_d  = 1'b1;
                        state_d = REP_RD;
                    end
                end
            end
            REP_RD: begin
                lb_re   = 1'b1;
                state_d = REP_A;
            end
            REP_A: begin
                // Buffer output is stable here, so dout stays valid across a stall.
                valid_out = 1'b1;
                dout      = lb_q;
                pix_d     = lb_q;
                if (ready_in) begin
                    state_d = REP_B;
                end
            end
            REP_B: begin
                valid_out = 1'b1;
                eol       = col_last;
                if (ready_in) begin
                    if (!col_last) begin
                        col_d   = col_q + CW'(1);
                        state_d = REP_RD;
                    end else begin
                        col_d   = '0;
                        pass_d  = 1'b0;
                        row_d   = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
                        state_d = FETCH;
                    end
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FETCH;
            col_q   <= '0;
            row_q   <= '0;
            pass_q  <= 1'b0;
            pix_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            pass_q  <= pass_d;
            pix_q   <= pix_d;
        end
    end

endmodule

// File: tb/tb_up_sampler.sv
// Bench for up_sampler in a 2x2 configuration: FIFO model, transfer monitor, vector table and random model check.
module tb_up_sampler;

    localparam int W = 2;
    localparam int H = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       empty;
    logic       rd_en;
    logic [7:0] din;
    logic       valid;
    logic       ready_in;
    logic       valid_out;
    logic [7:0] dout;
    logic       sof;
    logic       eol;

    up_sampler #(.IN_WIDTH(W), .IN_HEIGHT(H)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .empty     (empty),
        .rd_en     (rd_en),
        .din       (din),
        .valid     (valid),
        .ready_in  (ready_in),
        .valid_out (valid_out),
        .dout      (dout),
        .sof       (sof),
        .eol       (eol)
    );

    always #5 clk = ~clk;

    // FIFO storage: main process appends, FIFO process consumes.
    logic [7:0] fifo_mem [0:1023];
    int         wr_idx;
    int         rd_idx;

    // Transfers and protocol-violation counters collected by the monitor.
    logic [7:0] out_dat [$];
    logic       out_sof [$];
    logic       out_eol [$];
    int         rd_cnt;
    int         stab_err;
    int         bad_rd;
    int         marker_err;

    int errors;
    int checks;

    typedef struct {
        logic [7:0] dat;
        logic       sof;
        logic       eol;
    } vec_t;

    vec_t       tbl [16];
    int         tbl_d [16] = '{10, 10, 20, 20, 10, 10, 20, 20, 30, 30, 40, 40, 30, 30, 40, 40};

    logic [7:0] exp_dat [$];
    logic       exp_sof [$];
    logic       exp_eol [$];

    // FIFO read side: pop on an rd_en cycle, data valid the following cycle.
    initial begin
        logic take;
        valid  = 1'b0;
        din    = '0;
        empty  = 1'b1;
        rd_idx = 0;
        forever begin
            @(negedge clk);
            take = rd_en;
            @(posedge clk);
            #1;
            valid = 1'b0;
            if (take) begin
                din    = fifo_mem[rd_idx[9:0]];
                rd_idx = rd_idx + 1;
                valid  = 1'b1;
            end
            empty = (rd_idx == wr_idx);
        end
    end

    initial begin
        logic       pv, pr, ps, pe;
        logic [7:0] pd;
        pv = 0; pr = 0; ps = 0; pe = 0; pd = '0;
        rd_cnt = 0; stab_err = 0; bad_rd = 0; marker_err = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (pv && !pr && !(valid_out && dout == pd && sof == ps && eol == pe))
                    stab_err++;
                if (rd_en && valid_out) bad_rd++;
                if (!valid_out && (sof || eol)) marker_err++;
                if (rd_en) rd_cnt++;
                if (valid_out && ready_in) begin
                    out_dat.push_back(dout);
                    out_sof.push_back(sof);
                    out_eol.push_back(eol);
                end
                pv = valid_out; pr = ready_in; pd = dout; ps = sof; pe = eol;
            end else begin
                pv = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] v);
        fifo_mem[wr_idx[9:0]] = v;
        wr_idx = wr_idx + 1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic wait_out(input int target, input int bound, input string name);
        int n = 0;
        while (out_dat.size() < target && n < bound) begin
            @(posedge clk);
            n++;
        end
        #1;
        check(name, out_dat.size() >= target, 1);
    endtask

    // Wait until a given number of transfers is done and the next pixel is being presented.
    task automatic wait_presenting(input int count, input string name);
        int n = 0;
        while (!(out_dat.size() == count && valid_out) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, out_dat.size() == count && valid_out, 1);
    endtask

    // Reference: each pushed pixel appears twice, each line twice, frames tile from row 0.
    task automatic build_expected(input int first, input int npix);
        exp_dat.delete();
        exp_sof.delete();
        exp_eol.delete();
        for (int f = 0; f < npix / (W * H); f++)
            for (int r = 0; r < H; r++)
                for (int p = 0; p < 2; p++)
                    for (int c = 0; c < W; c++)
                        for (int k = 0; k < 2; k++) begin
                            exp_dat.push_back(fifo_mem[first + f * W * H + r * W + c]);
                            exp_sof.push_back(r == 0 && p == 0 && c == 0 && k == 0);
                            exp_eol.push_back(c == W - 1 && k == 1);
                        end
    endtask

    task automatic compare_model(input int base, input string tag);
        for (int i = 0; i < exp_dat.size(); i++) begin
            check($sformatf("%s_dat[%0d]", tag, i), out_dat[base + i], exp_dat[i]);
            check($sformatf("%s_sof[%0d]", tag, i), out_sof[base + i], exp_sof[i]);
            check($sformatf("%s_eol[%0d]", tag, i), out_eol[base + i], exp_eol[i]);
        end
    endtask

    task automatic compare_table(input int base, input string tag);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("%s_dat[%0d]", tag, i), out_dat[base + i], tbl[i].dat);
            check($sformatf("%s_sof[%0d]", tag, i), out_sof[base + i], tbl[i].sof);
            check($sformatf("%s_eol[%0d]", tag, i), out_eol[base + i], tbl[i].eol);
        end
    endtask

    initial begin
        int base, rc, first, viol, nsof, neol, pushed, n;
        errors = 0;
        checks = 0;
        wr_idx = 0;
        rst = 1'b0;
        ready_in = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tbl[i].dat = tbl_d[i][7:0];
            tbl[i].sof = (i == 0);
            tbl[i].eol = (i % 4 == 3);
        end

        // Reset state with a non-empty FIFO: nothing may be popped or emitted.
        repeat (2) @(posedge clk);
        #1;
        push(10); push(20); push(30); push(40);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_rd_en", rd_en, 0);
        check("reset_valid_out", valid_out, 0);
        check("reset_dout", dout, 0);
        check("reset_sof", sof, 0);
        check("reset_eol", eol, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Basic 2x2 frame.
        base = out_dat.size();
        rc = rd_cnt;
        wait_out(base + 16, 200, "frame1_done");
        compare_table(base, "f1");
        check("frame1_pops", rd_cnt - rc, 4);

        // Same frame again with stalls in EMIT_A of pixel 20 and in a replay REP_B.
        base = out_dat.size();
        rc = rd_cnt;
        push(10); push(20); push(30); push(40);
        wait_presenting(base + 2, "bp1_reach");
        ready_in = 1'b0;
        n = rd_cnt;
        repeat (5) @(posedge clk);
        #1;
        check("bp1_dout", dout, 20);
        check("bp1_valid", valid_out, 1);
        check("bp1_no_pop", rd_cnt - n, 0);
        ready_in = 1'b1;
        wait_presenting(base + 5, "bp2_reach");
        ready_in = 1'b0;
        n = rd_cnt;
        repeat (5) @(posedge clk);
        #1;
        check("bp2_dout", dout, 10);
        check("bp2_eol", eol, 0);
        check("bp2_no_pop", rd_cnt - n, 0);
        ready_in = 1'b1;
        wait_out(base + 16, 200, "frame2_done");
        compare_table(base, "f2");
        check("frame2_pops", rd_cnt - rc, 4);

        // Empty FIFO: idle with no pops and no output, then a single pixel.
        do_reset();
        viol = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rd_en || valid_out) viol++;
        end
        check("empty_idle", viol, 0);
        base = out_dat.size();
        @(posedge clk);
        #1;
        push(7);
        wait_out(base + 2, 100, "empty_px_done");
        check("empty_dat0", out_dat[base], 7);
        check("empty_dat1", out_dat[base + 1], 7);
        check("empty_sof0", out_sof[base], 1);
        check("empty_sof1", out_sof[base + 1], 0);

        // Back-to-back frames: row wraps, sof on first pixel of each frame only.
        do_reset();
        base = out_dat.size();
        first = wr_idx;
        for (int i = 1; i <= 8; i++) push(8'(i));
        build_expected(first, 8);
        wait_out(base + 32, 400, "b2b_done");
        compare_model(base, "b2b");
        nsof = 0;
        for (int i = 0; i < 32; i++) if (out_sof[base + i]) nsof++;
        check("b2b_sof_count", nsof, 2);
        check("b2b_sof_17", out_sof[base + 16], 1);

        // Reset during replay of the first line aborts it.
        do_reset();
        base = out_dat.size();
        push(91); push(92);
        wait_presenting(base + 4, "abort_reach");
        rst = 1'b0;
        @(negedge clk);
        check("abort_valid_out", valid_out, 0);
        check("abort_dout", dout, 0);
        check("abort_sof", sof, 0);
        check("abort_eol", eol, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        base = out_dat.size();
        first = wr_idx;
        push(50); push(60); push(70); push(80);
        build_expected(first, 4);
        wait_out(base + 16, 200, "abort_frame_done");
        compare_model(base, "abort");

        // Random pixels, random FIFO arrival gaps, random ready_in over three frames.
        do_reset();
        base = out_dat.size();
        rc = rd_cnt;
        first = wr_idx;
        pushed = 0;
        n = 0;
        while (out_dat.size() < base + 48 && n < 3000) begin
            @(posedge clk);
            #1;
            ready_in = ($urandom_range(0, 3) != 0);
            if (pushed < 12 && $urandom_range(0, 2) == 0) begin
                push(8'($urandom));
                pushed++;
            end
            n++;
        end
        ready_in = 1'b1;
        check("rand_done", out_dat.size() >= base + 48, 1);
        build_expected(first, 12);
        compare_model(base, "rand");
        check("rand_pops", rd_cnt - rc, 12);
        neol = 0;
        for (int i = 0; i < 48; i++) if (out_eol[base + i]) neol++;
        check("rand_eol_count", neol, 12);

        repeat (4) @(posedge clk);
        check("hold_stable", stab_err, 0);
        check("pop_while_output", bad_rd, 0);
        check("marker_without_valid", marker_err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/up_sampler.md
# up_sampler

Upscale stage directly downstream of the Gaussian blur FIFO. It pops 8-bit pixels from the FIFO's read side and emits a 2x nearest-neighbour upsampled frame. Each input pixel is emitted twice horizontally, and each input line is emitted twice vertically by replaying it from an internal line buffer. The output is a valid/ready pixel stream with start-of-frame and end-of-line markers for the next stage.

## Interface
- IN_WIDTH, 320: input pixels per line; output line is 2*IN_WIDTH.
- IN_HEIGHT, 240: input lines per frame; output frame is 2*IN_HEIGHT lines.
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- empty  in  1  FIFO empty flag.
- rd_en  out  1  FIFO read strobe, one pop per high cycle.
- din  in  8  FIFO read data, meaningful when valid=1.
- valid  in  1  FIFO data valid, one cycle after an accepted rd_en.
- ready_in  in  1  downstream can accept dout this cycle.
- valid_out  out  1  dout holds a pixel.
- dout  out  8  output pixel.
- sof  out  1  with valid_out: first pixel of output frame.
- eol  out  1  with valid_out: last pixel of an output line.

## Operation
- Line buffer: IN_WIDTH x 8, synchronous write, synchronous read (1-cycle read latency). Contents are not cleared by reset.
- Counters:
  - col, 0..IN_WIDTH-1, $clog2(IN_WIDTH) bits.
  - row, 0..IN_HEIGHT-1.
  - pass, 0 = live line, 1 = replay.
  - Counters wrap to 0 exactly at their limit, never beyond.
- FSM states: FETCH, WAIT, EMIT_A, EMIT_B, REP_RD, REP_A, REP_B.
  - FETCH: rd_en=1 iff empty=0. If rd_en is asserted, go to WAIT; otherwise stay.
  - WAIT: rd_en=0. Stay until valid=1. On valid, capture din into pix_reg and write the line buffer at col. Go to EMIT_A.
  - EMIT_A: valid_out=1, dout=pix_reg. Go to EMIT_B when ready_in=1.
  - EMIT_B: valid_out=1, dout=pix_reg. On ready_in=1:
    - If col<IN_WIDTH-1: col++, go to FETCH.
    - Else: col=0, pass=1, go to REP_RD.
  - REP_RD: valid_out=0. Line-buffer read address = col. Go to REP_A.
  - REP_A: latch buffer data into pix_reg. valid_out=1. Go to REP_B when ready_in=1.
  - REP_B: valid_out=1. On ready_in=1:
    - If col<IN_WIDTH-1: col++, go to REP_RD.
    - Else: col=0, pass=0. If row<IN_HEIGHT-1, row++; else row=0 (frame done). Go to FETCH.
- sof=1 in EMIT_A when row=0, col=0, pass=0; otherwise 0.
- eol=1 in EMIT_B or REP_B when col=IN_WIDTH-1; otherwise 0.
- sof and eol are 0 whenever valid_out=0.
- Exactly IN_WIDTH*IN_HEIGHT pops per frame. No rd_en is issued outside FETCH.

## Timing
- Reset values: rd_en=0, valid_out=0, dout=0, sof=0, eol=0, state=FETCH, col=row=pass=0.
- Reset asserted mid-line aborts the line. The first pixel popped after reset release is treated as row 0, col 0, and flagged sof.
- Pop-to-output latency: rd_en at cycle t, valid at t+1, first valid_out at t+2.
- Steady-state throughput with ready_in=1:
  - Live pass: 2 output pixels per 4 cycles (FETCH, WAIT, EMIT_A, EMIT_B).
  - Replay pass: 2 output pixels per 3 cycles.
- Handshake: a transfer occurs on a cycle where valid_out=1 and ready_in=1. While valid_out=1 and ready_in=0, dout, sof and eol hold stable and the state is frozen.
- valid_out never deasserts without a completed transfer.
- empty=1 in FETCH: rd_en stays 0 and the FSM idles indefinitely with no output.
- valid=0 in WAIT (FIFO latency stretch): hold in WAIT; no spurious writes.
- ready_in is ignored in FETCH, WAIT and REP_RD.

## Test plan
- 2x2 frame (IN_WIDTH=2, IN_HEIGHT=2), FIFO holds 10,20,30,40, ready_in=1:
  - dout = 10,10,20,20, 10,10,20,20, 30,30,40,40, 30,30,40,40.
  - sof only on the first pixel; eol on pixels 4, 8, 12, 16.
  - Exactly 4 rd_en pulses.
- Backpressure: drop ready_in for 5 cycles during EMIT_A of pixel 20, and again during REP_B:
  - dout/sof/eol stay stable.
  - No rd_en is issued.
  - The output sequence is unchanged.
- Empty FIFO: empty=1 for 50 cycles after reset. Then rd_en=0 and valid_out=0 throughout. Pushing one pixel (7) then yields 7,7 with sof=1 on the first.
- Back-to-back frames: push 8 pixels with a 2x2 configuration. sof is asserted on output pixels 1 and 17 only, and row wraps to 0.
- Async reset mid-line: assert rst low during REP_A of frame 1, then release and push 50,60,70,80. Outputs are 0 during reset, and the new frame starts at 50 with sof=1.
- Default size (320x240) with random ready_in:
  - 76800 pops per frame and 307200 transfers.
  - 480 eol pulses, each on a 640th transfer.
